// File: rtl/simt_scheduler_pkg.sv
// Shared definitions for the SIMT scheduler slice.
//   core_state_t    : scheduler FSM encoding, which is also the core_state output
//   FETCHER_FETCHED : fetcher state code meaning the instruction word is ready
//   LSU_*           : per-lane LSU state codes
//   lsu_busy()      : true while a lane's LSU still has a request in flight
package simt_scheduler_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;

    localparam logic [1:0] LSU_IDLE       = 2'b00;
    localparam logic [1:0] LSU_REQUESTING = 2'b01;
    localparam logic [1:0] LSU_WAITING    = 2'b10;
    localparam logic [1:0] LSU_DONE       = 2'b11;

    function automatic logic lsu_busy(input logic [1:0] s);
        return (s == LSU_REQUESTING) || (s == LSU_WAITING);
    endfunction

endpackage

// File: rtl/simt_scheduler_if.sv
// Bundle connecting the SIMT scheduler to its fetcher, decoder, LSUs and PC units.
//   master : the core environment (drives launch, fetch, decode, LSU and next-PC info)
//   slave  : the scheduler (drives core_state, current_pc, active_mask, diverged, done)
// Lane i of lsu_state sits at [2i+1:2i]; lane i of next_pc sits at [A*i+A-1:A*i].
interface simt_scheduler_if #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
);
    localparam int T  = THREADS_PER_BLOCK;
    localparam int A  = PROGRAM_MEM_ADDR_BITS;
    localparam int CW = $clog2(T) + 1;

    logic                               start;
    logic [CW-1:0]                      thread_count;
    logic [2:0]                         fetcher_state;
    logic                               decoded_mem_read_enable;
    logic                               decoded_mem_write_enable;
    logic                               decoded_ret;
    logic [2*T-1:0]                     lsu_state;
    logic [A*T-1:0]                     next_pc;
    simt_scheduler_pkg::core_state_t    core_state;
    logic [A-1:0]                       current_pc;
    logic [T-1:0]                       active_mask;
    logic                               diverged;
    logic                               done;

    modport master (
        output start, thread_count, fetcher_state, decoded_mem_read_enable,
               decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
        input  core_state, current_pc, active_mask, diverged, done
    );

    modport slave (
        input  start, thread_count, fetcher_state, decoded_mem_read_enable,
               decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
        output core_state, current_pc, active_mask, diverged, done
    );

endinterface

// File: rtl/simt_scheduler_pc_min_select.sv
// pc_min_select: finds the smallest PC among valid lanes (unsigned) and the set
// of valid lanes sitting at that PC.
//   pcs        : lane i PC at [A*i+A-1:A*i]
//   valid      : lanes taking part in the selection
//   min_pc     : minimum PC over valid lanes (don't-care when none valid)
//   match_mask : valid lanes whose PC equals min_pc
//   any_valid  : at least one lane is valid
module pc_min_select #(
    parameter int T = 4,
    parameter int A = 8
) (
    input  logic [A*T-1:0] pcs,
    input  logic [T-1:0]   valid,
    output logic [A-1:0]   min_pc,
    output logic [T-1:0]   match_mask,
    output logic           any_valid
);
    // Leaves padded to a power of two so the reduction is a balanced tree.
    localparam int N = (T <= 1) ? 1 : (1 << $clog2(T));

    always_comb begin
        logic [A-1:0] lvl_pc [N];
        logic         lvl_v  [N];
        logic [A-1:0] a_pc;
        logic [A-1:0] b_pc;
        logic         a_v;
        logic         b_v;
        a_pc = '0;
        b_pc = '0;
        a_v  = 1'b0;
        b_v  = 1'b0;
        for (int i = 0; i < N; i++) begin
            lvl_pc[i] = '0;
            lvl_v[i]  = 1'b0;
            if (i < T) begin
                lvl_pc[i] = pcs[A*i +: A];
                lvl_v[i]  = valid[i];
            end
        end
        // Each pass halves the level in place; node j reads 2j/2j+1 before writing j.
        for (int w = N; w > 1; w = w / 2) begin
            for (int j = 0; j < w / 2; j++) begin
                a_pc = lvl_pc[2*j];
                a_v  = lvl_v[2*j];
                b_pc = lvl_pc[2*j+1];
                b_v  = lvl_v[2*j+1];
                lvl_v[j]  = a_v | b_v;
                lvl_pc[j] = (b_v && (!a_v || (b_pc < a_pc))) ? b_pc : a_pc;
            end
        end
        min_pc    = lvl_pc[0];
        any_valid = lvl_v[0];
        match_mask = '0;
        for (int i = 0; i < T; i++) begin
            match_mask[i] = valid[i] && (pcs[A*i +: A] == lvl_pc[0]);
        end
    end

endmodule

// File: rtl/simt_scheduler.sv
// simt_scheduler: per-core sequencer for one thread block with per-lane PCs.
// Each instruction issues to the live lanes sitting at the minimum live PC, so
// divergent paths run one after another and reconverge when their PCs meet.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : simt_scheduler_if.slave (launch, fetch/decode/LSU status,
//                next PCs in; core_state, current_pc, active_mask, diverged, done out)
//
// state        | meaning
// CORE_IDLE    | waiting for start
// CORE_FETCH   | waiting for the fetcher to return the instruction at current_pc
// CORE_DECODE  | decoder working, one cycle
// CORE_REQUEST | LSUs issue requests, one cycle
// CORE_WAIT    | hold until no active lane has an LSU request in flight
// CORE_EXECUTE | ALUs compute, one cycle
// CORE_UPDATE  | commit lane PCs/retirement and pick the next issue group
// CORE_DONE    | block finished, hold until reset
module simt_scheduler
    import simt_scheduler_pkg::*;
#(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    simt_scheduler_if.slave  bus
);
    localparam int T  = THREADS_PER_BLOCK;
    localparam int A  = PROGRAM_MEM_ADDR_BITS;
    localparam int CW = $clog2(T) + 1;

    core_state_t    state;
    logic [A-1:0]   current_pc;
    logic [T-1:0]   active_mask;
    logic [T-1:0]   live;
    logic [A*T-1:0] thread_pc;
    logic           done_q;

    logic [CW-1:0]  count_clamped;
    logic [T-1:0]   launch_mask;
    logic [T-1:0]   post_live;
    logic [A*T-1:0] post_pc;
    logic [A-1:0]   min_pc;
    logic [T-1:0]   match_mask;
    logic           any_live;
    logic           lsu_stall;

    // Memory-op flags steer the LSUs directly; the scheduler only watches LSU state.
    logic           unused_mem_flags;
    assign unused_mem_flags = bus.decoded_mem_read_enable ^ bus.decoded_mem_write_enable;

    always_comb begin
        count_clamped = (int'(bus.thread_count) > T) ? CW'(T) : bus.thread_count;
        launch_mask   = '0;
        post_live     = '0;
        post_pc       = '0;
        lsu_stall     = 1'b0;
        for (int i = 0; i < T; i++) begin
            launch_mask[i]   = (i < int'(count_clamped));
            post_pc[A*i +: A] = active_mask[i] ? bus.next_pc[A*i +: A] : thread_pc[A*i +: A];
            post_live[i]     = live[i] & ~(active_mask[i] & bus.decoded_ret);
            if (active_mask[i] && lsu_busy(bus.lsu_state[2*i +: 2])) begin
                lsu_stall = 1'b1;
            end
        end
    end

    // Selection sees the post-UPDATE view so the next group is known on the UPDATE edge.
    pc_min_select #(.T(T), .A(A)) u_min_select (
        .pcs        (post_pc),
        .valid      (post_live),
        .min_pc     (min_pc),
        .match_mask (match_mask),
        .any_valid  (any_live)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CORE_IDLE;
            current_pc  <= '0;
            active_mask <= '0;
            live        <= '0;
            thread_pc   <= '0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                CORE_IDLE: begin
                    if (bus.start) begin
                        if (count_clamped == '0) begin
                            state  <= CORE_DONE;
                            done_q <= 1'b1;
                        end else begin
                            live        <= launch_mask;
                            active_mask <= launch_mask;
                            thread_pc   <= '0;
                            current_pc  <= '0;
                            state       <= CORE_FETCH;
                        end
                    end
                end
                CORE_FETCH: begin
                    if (bus.fetcher_state == FETCHER_FETCHED) state <= CORE_DECODE;
                end
                CORE_DECODE:  state <= CORE_REQUEST;
                CORE_REQUEST: state <= CORE_WAIT;
                CORE_WAIT: begin
                    if (!lsu_stall) state <= CORE_EXECUTE;
                end
                CORE_EXECUTE: state <= CORE_UPDATE;
                CORE_UPDATE: begin
                    thread_pc <= post_pc;
                    live      <= post_live;
                    if (any_live) begin
                        current_pc  <= min_pc;
                        active_mask <= match_mask;
                        state       <= CORE_FETCH;
                    end else begin
                        active_mask <= '0;
                        state       <= CORE_DONE;
                        done_q      <= 1'b1;
                    end
                end
                CORE_DONE: state <= CORE_DONE;
                default:   state <= CORE_IDLE;
            endcase
        end
    end

    assign bus.core_state  = state;
    assign bus.current_pc  = current_pc;
    assign bus.active_mask = active_mask;
    assign bus.done        = done_q;
    assign bus.diverged    = (active_mask != live);

endmodule

// File: doc/simt_scheduler.md
# simt_scheduler

Per-core control block that sequences the fetch/decode/request/wait/execute/update pipeline for one thread block. It supersedes the single-PC scheduler by tracking a program counter and retirement flag per thread, so it can handle branch divergence. Each instruction is issued only to the threads whose PC equals the minimum live PC (min-PC reconvergence). It sits between the fetcher, decoder, per-thread LSUs and per-thread PC units inside a core, and drives the per-thread enables.

## Interface
- THREADS_PER_BLOCK, 4, thread lanes in the core (T); ≥1
- PROGRAM_MEM_ADDR_BITS, 8, PC width (A)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  in  1  launch block; sampled only in IDLE
- thread_count  in  $clog2(T)+1  threads in block, latched at start; values >T clamp to T
- fetcher_state  in  3  fetcher FSM state; FETCHED = 3'b010
- decoded_mem_read_enable  in  1  current instruction is a load
- decoded_mem_write_enable  in  1  current instruction is a store
- decoded_ret  in  1  current instruction is RET
- lsu_state  in  2*T  per-thread LSU state, lane i at [2i+1:2i]; IDLE 00, REQUESTING 01, WAITING 10, DONE 11
- next_pc  in  A*T  per-thread next PC from PC units, lane i at [A*i+A-1:A*i]
- core_state  out  3  IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111
- current_pc  out  A  PC of the instruction being issued
- active_mask  out  T  per-thread enable for ALU/LSU/regfile/PC units this instruction
- diverged  out  1  high when active_mask ≠ live mask (live = launched and not retired)
- done  out  1  block complete

## Operation
- Internal state:
  - thread_pc[T] (A bits each)
  - live[T]
  - count_q (clamped thread_count)
- IDLE: on start, the next state depends on count_q.
  - count_q = 0: go to DONE.
  - Otherwise: live = low count_q bits set, thread_pc = 0, current_pc = 0, active_mask = live, then go to FETCH.
- FETCH → DECODE when fetcher_state = FETCHED; otherwise hold.
- DECODE → REQUEST → WAIT, one cycle each, unconditional.
- WAIT → EXECUTE once no lane with active_mask[i]=1 has lsu_state 01 or 10.
  - Inactive lanes are ignored.
  - Holds indefinitely on a stalled LSU.
- EXECUTE → UPDATE, one cycle.
- UPDATE, for each lane with active_mask[i]=1:
  - thread_pc[i] ← next_pc[i]
  - if decoded_ret: live[i] ← 0
- Also in UPDATE, the post-update PCs of live lanes feed the selection:
  - Lanes not active keep their thread_pc.
  - Retiring lanes are excluded.
  - m = minimum post-update PC over the remaining lanes, unsigned compare.
  - current_pc ← m; active_mask ← {live' lanes with PC = m}; go to FETCH.
  - If no live lanes remain: active_mask ← 0; go to DONE.
- Ties: all lanes at the minimum PC issue together; this is how divergent paths reconverge.
- PC wrap: next_pc is taken modulo 2^A as supplied. There is no special handling, so a wrapped PC of 0 is the minimum.
- DONE: done = 1 and the state holds until reset; start is ignored.
- start outside IDLE is ignored.
- thread_count changes after launch are ignored.

## Timing
- Reset values: core_state IDLE, current_pc 0, active_mask 0, diverged 0, done 0, thread_pc all 0, live all 0, count_q 0.
- Reset mid-operation forces IDLE and all reset values asynchronously; there is no drain.
- All outputs are registered, except diverged, which is combinational from active_mask and live.
- Minimum instruction period is 6 cycles (FETCH through UPDATE), when the fetch and WAIT each take one cycle.
- active_mask and current_pc change only on the UPDATE→FETCH edge or the launch edge. They are stable from FETCH through UPDATE.
- done asserts on the first cycle in DONE: one cycle after UPDATE of the last RET, or one cycle after start with count_q = 0.

## Structure
- Shared package (gpu_pkg):
  - core_state encodings
  - FETCHED fetcher code
  - LSU state codes
- Sub-module pc_min_select: combinational, parametrised T/A.
  - Inputs: candidate PCs and valid mask.
  - Outputs: min PC, match mask, any_valid.
  - Built as a balanced compare tree.
- The FSM and lane registers live in simt_scheduler. Expected size is 150–300 lines total.

## Test plan
- Uniform flow: T=4, thread_count=4; every next_pc = pc+1 for 3 instructions, then RET at pc 3.
  - Required: current_pc 0,1,2,3; active_mask 1111 throughout; diverged 0.
  - done rises one cycle after the UPDATE at pc 3.
- Divergence and reconvergence: at pc 2, lanes 0,1 branch to 6 and lanes 2,3 go to 3; both paths reach 6.
  - Required: pc 3 issues with mask 1100 (lanes 2,3) and diverged=1, continuing until those lanes reach 6.
  - Then pc 6 issues with mask 1111 and diverged=0.
- Partial block: thread_count=3.
  - Required: active_mask 0111 from launch; lane 3 never enabled; done after lanes 0–2 RET.
  - With thread_count=7 on T=4, count clamps to 4.
- LSU stall: load with lane 1 lsu_state held at 10 for 5 cycles.
  - Required: WAIT held 5 cycles, EXECUTE only after lane 1 reaches 11.
  - An inactive lane stuck at 01 does not stall.
- Staggered RET: lanes 0,1 RET at pc 4; lanes 2,3 RET later at pc 9.
  - Required: mask 1100 after pc 4 and done only after pc 9's UPDATE.
- Edge cases, three separate checks:
  - Reset asserted in WAIT: core_state = IDLE and all outputs at reset values immediately.
  - thread_count=0 at start: DONE one cycle later.
  - start pulsed in DONE: no effect.
